// File: rtl/pipeline_stage0_if.sv
// pipeline_stage0_if: fetch-stage bus/pipe bundle; BubbleCount exists only with STAGE0_BUBBLE_COUNT_EN
interface pipeline_stage0_if;
    logic [7:0]  BusData;
    logic        BusRequest;
    logic        FetchSuppress;
    logic        PCLoad;
    logic [7:0]  PipeOut;
    logic [15:0] ImmOut;
    logic        ImmValid;
    logic        PCInc;
    logic        FetchEn;
`ifdef STAGE0_BUBBLE_COUNT_EN
    logic [15:0] BubbleCount;
    modport master (
        output BusData, BusRequest, FetchSuppress, PCLoad,
        input  PipeOut, ImmOut, ImmValid, PCInc, FetchEn, BubbleCount
    );
    modport slave (
        input  BusData, BusRequest, FetchSuppress, PCLoad,
        output PipeOut, ImmOut, ImmValid, PCInc, FetchEn, BubbleCount
    );
`else
    modport master (
        output BusData, BusRequest, FetchSuppress, PCLoad,
        input  PipeOut, ImmOut, ImmValid, PCInc, FetchEn
    );
    modport slave (
        input  BusData, BusRequest, FetchSuppress, PCLoad,
        output PipeOut, ImmOut, ImmValid, PCInc, FetchEn
    );
`endif
endinterface

// File: rtl/pipeline_stage0.sv
// pipeline_stage0: instruction fetch; registers opcodes onto the pipe, inserts NOP bubbles,
// collects immediate bytes onto ImmOut. Optional STAGE0_BUBBLE_COUNT_EN adds a saturating
// count of stall/flush bubbles.
module pipeline_stage0 (
    input  logic              ClockIn,
    input  logic              ResetIn_n,
    pipeline_stage0_if.slave  bus
);
    typedef enum logic [1:0] {OP, IMM1, IMMLO, IMMHI} state_t;

    state_t      state, state_nxt;
    logic [7:0]  pipe_q, pipe_nxt;
    logic [15:0] imm_q, imm_nxt;
    logic        imm_valid_q, imm_valid_nxt;
    logic [7:0]  imm_lo, imm_lo_nxt;
    logic        stall;

    assign stall        = bus.BusRequest | bus.FetchSuppress;
    assign bus.PCInc    = !bus.PCLoad && !stall;
    assign bus.FetchEn  = !bus.BusRequest;
    assign bus.PipeOut  = pipe_q;
    assign bus.ImmOut   = imm_q;
    assign bus.ImmValid = imm_valid_q;

    // next state and registered outputs: flush beats stall beats normal fetch
    always_comb begin
        state_nxt     = state;
        pipe_nxt      = 8'h00;
        imm_nxt       = imm_q;
        imm_valid_nxt = 1'b0;
        imm_lo_nxt    = imm_lo;
        if (bus.PCLoad) begin
            state_nxt  = OP;
            imm_lo_nxt = 8'h00;
        end else if (!stall) begin
            case (state)
                OP: begin
                    pipe_nxt  = bus.BusData;
                    state_nxt = bus.BusData[7] ? (bus.BusData[6] ? IMMLO : IMM1) : OP;
                end
                IMM1: begin
                    imm_nxt       = {8'h00, bus.BusData};
                    imm_valid_nxt = 1'b1;
                    state_nxt     = OP;
                end
                IMMLO: begin
                    imm_lo_nxt = bus.BusData;
                    state_nxt  = IMMHI;
                end
                IMMHI: begin
                    imm_nxt       = {bus.BusData, imm_lo};
                    imm_valid_nxt = 1'b1;
                    state_nxt     = OP;
                end
                default: state_nxt = OP;
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state       <= OP;
            pipe_q      <= 8'h00;
            imm_q       <= 16'h0000;
            imm_valid_q <= 1'b0;
            imm_lo      <= 8'h00;
        end else begin
            state       <= state_nxt;
            pipe_q      <= pipe_nxt;
            imm_q       <= imm_nxt;
            imm_valid_q <= imm_valid_nxt;
            imm_lo      <= imm_lo_nxt;
        end
    end

`ifdef STAGE0_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt;

    assign bus.BubbleCount = bubble_cnt;

    // saturating count of bubbles caused by stall or flush; immediate slots are not counted
    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n)
            bubble_cnt <= 16'h0000;
        else if ((bus.PCLoad || stall) && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'h0001;
    end
`else
`endif
endmodule

// File: tb/tb_pipeline_stage0.sv
// tb_pipeline_stage0: directed self-checking bench for the fetch stage
module tb_pipeline_stage0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_stage0_if bus();

    pipeline_stage0 dut (
        .ClockIn  (clk),
        .ResetIn_n(rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] d, input logic br, input logic fs, input logic pl);
        bus.BusData       = d;
        bus.BusRequest    = br;
        bus.FetchSuppress = fs;
        bus.PCLoad        = pl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [7:0] seq [3];
        seq[0] = 8'h05; seq[1] = 8'h41; seq[2] = 8'h3F;
        for (int i = 0; i < 3; i++) begin
            drive(seq[i], 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.PCInc !== 1'b1) begin errors++; $display("FAIL stream_pcinc[%0d]: got %b expected 1", i, bus.PCInc); end
            checks++;
            if (bus.FetchEn !== 1'b1) begin errors++; $display("FAIL stream_fetchen[%0d]: got %b expected 1", i, bus.FetchEn); end
            tick();
            checks++;
            if (bus.PipeOut !== seq[i]) begin errors++; $display("FAIL stream_pipe[%0d]: got %h expected %h", i, bus.PipeOut, seq[i]); end
        end
    endtask

    task automatic test_imm1();
        drive(8'h85, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'h85) begin errors++; $display("FAIL imm1_op: got %h expected 85", bus.PipeOut); end
        drive(8'h7E, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL imm1_nop: got %h expected 00", bus.PipeOut); end
        checks++;
        if (bus.ImmOut !== 16'h007E) begin errors++; $display("FAIL imm1_val: got %h expected 007e", bus.ImmOut); end
        checks++;
        if (bus.ImmValid !== 1'b1) begin errors++; $display("FAIL imm1_valid: got %b expected 1", bus.ImmValid); end
        drive(8'h05, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL imm1_pulse: got %b expected 0", bus.ImmValid); end
        checks++;
        if (bus.ImmOut !== 16'h007E) begin errors++; $display("FAIL imm1_hold: got %h expected 007e", bus.ImmOut); end
        checks++;
        if (bus.PipeOut !== 8'h05) begin errors++; $display("FAIL imm1_next_op: got %h expected 05", bus.PipeOut); end
    endtask

    task automatic test_imm2_stall();
        drive(8'hC2, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'hC2) begin errors++; $display("FAIL imm2_op: got %h expected c2", bus.PipeOut); end
        drive(8'h34, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL imm2_lo_nop: got %h expected 00", bus.PipeOut); end
        checks++;
        if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL imm2_lo_valid: got %b expected 0", bus.ImmValid); end
        for (int i = 0; i < 2; i++) begin
            drive(8'h12, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.PCInc !== 1'b0) begin errors++; $display("FAIL imm2_stall_pcinc[%0d]: got %b expected 0", i, bus.PCInc); end
            checks++;
            if (bus.FetchEn !== 1'b0) begin errors++; $display("FAIL imm2_stall_fetchen[%0d]: got %b expected 0", i, bus.FetchEn); end
            tick();
            checks++;
            if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL imm2_stall_pipe[%0d]: got %h expected 00", i, bus.PipeOut); end
            checks++;
            if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL imm2_stall_valid[%0d]: got %b expected 0", i, bus.ImmValid); end
        end
        drive(8'h12, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL imm2_hi_nop: got %h expected 00", bus.PipeOut); end
        checks++;
        if (bus.ImmOut !== 16'h1234) begin errors++; $display("FAIL imm2_val: got %h expected 1234", bus.ImmOut); end
        checks++;
        if (bus.ImmValid !== 1'b1) begin errors++; $display("FAIL imm2_valid: got %b expected 1", bus.ImmValid); end
    endtask

    task automatic test_flush();
        drive(8'hC0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'h55, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'hAA, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.PCInc !== 1'b0) begin errors++; $display("FAIL flush_pcinc: got %b expected 0", bus.PCInc); end
        checks++;
        if (bus.FetchEn !== 1'b1) begin errors++; $display("FAIL flush_fetchen: got %b expected 1", bus.FetchEn); end
        tick();
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL flush_pipe: got %h expected 00", bus.PipeOut); end
        checks++;
        if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.ImmValid); end
        drive(8'h10, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.PipeOut !== 8'h10) begin errors++; $display("FAIL flush_next_op: got %h expected 10", bus.PipeOut); end
        checks++;
        if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", bus.ImmValid); end
        checks++;
        if (bus.ImmOut !== 16'h1234) begin errors++; $display("FAIL flush_imm_hold: got %h expected 1234", bus.ImmOut); end
    endtask

    task automatic test_reset();
        drive(8'h85, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'h21, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL reset_pipe: got %h expected 00", bus.PipeOut); end
        checks++;
        if (bus.ImmOut !== 16'h0000) begin errors++; $display("FAIL reset_imm: got %h expected 0000", bus.ImmOut); end
        checks++;
        if (bus.ImmValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ImmValid); end
        tick();
        checks++;
        if (bus.PipeOut !== 8'h00) begin errors++; $display("FAIL reset_held_pipe: got %h expected 00", bus.PipeOut); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.PipeOut !== 8'h21) begin errors++; $display("FAIL reset_first_fetch: got %h expected 21", bus.PipeOut); end
    endtask

`ifdef STAGE0_BUBBLE_COUNT_EN
    task automatic test_bubble_count();
        checks++;
        if (bus.BubbleCount !== 16'h0000) begin errors++; $display("FAIL bubble_start: got %h expected 0000", bus.BubbleCount); end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(8'h00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'hC1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (bus.BubbleCount !== 16'h0004) begin errors++; $display("FAIL bubble_four: got %h expected 0004", bus.BubbleCount); end
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        checks++;
        if (bus.BubbleCount !== 16'hFFFF) begin errors++; $display("FAIL bubble_saturate: got %h expected ffff", bus.BubbleCount); end
    endtask
`endif

    initial begin
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        test_stream();
        test_imm1();
        test_imm2_stall();
        test_flush();
        test_reset();
`ifdef STAGE0_BUBBLE_COUNT_EN
        test_bubble_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
